// File: rtl/cte_rgb_fifo.sv
// First-word-fall-through FIFO buffering 24-bit CTE pixels toward a ready/valid sink.
// Define CTE_RGB_FIFO_OVF_EN to add sticky overflow flag and saturating drop counter outputs.
module cte_rgb_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [23:0]              wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [23:0]              rd_data,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level
`ifdef CTE_RGB_FIFO_OVF_EN
  ,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [23:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_d;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = (r_level != '0) && rd_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push = wr_en && (!w_full || w_pop);

  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + 1'b1;
      2'b01:   w_level_d = r_level - 1'b1;
      default: w_level_d = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_d;
    end
  end

  // Storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data     = r_mem[r_rd_ptr];
  assign rd_valid    = (r_level != '0);
  assign almost_full = (r_level >= LW'(AF_LEVEL));
  assign level       = r_level;

`ifdef CTE_RGB_FIFO_OVF_EN
  logic       w_drop;
  logic       r_ovf;
  logic [7:0] r_drop_cnt;

  assign w_drop = wr_en && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;
`else
  // Without telemetry a push into a full FIFO is dropped silently.
`endif

endmodule

// File: tb/tb_cte_rgb_fifo.sv
// Scoreboard bench for cte_rgb_fifo: stimulus queues expected pixels, a negedge monitor checks pops.
module tb_cte_rgb_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        rd_ready;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        almost_full;
  logic [3:0]  level;
`ifdef CTE_RGB_FIFO_OVF_EN
  logic        ovf;
  logic [7:0]  drop_cnt;
`endif

  cte_rgb_fifo #(.DEPTH(8), .AF_LEVEL(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .almost_full (almost_full),
    .level       (level)
`ifdef CTE_RGB_FIFO_OVF_EN
    ,
    .ovf         (ovf),
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake is stable between drive points, so sample at the falling edge.
  always @(negedge clk) begin
    if (reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(rd_data), 32'hFFFF_FFFF);
      end else begin
        chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
        rx_cnt++;
      end
    end
  end

  function automatic logic [23:0] golden(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h0001_0F1D + 32'h00A5_3C01;
    return v[23:0];
  endfunction

  initial begin
    int sent;
    int cyc;
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_af", 32'(almost_full), 0);
    step();
    step();
    reset = 1'b1;
    step();

    // Single push, no bypass
    wr_en = 1'b1; wr_data = 24'h123456;
    #1;
    chk("nobypass_valid", 32'(rd_valid), 0);
    step();
    wr_en = 1'b0;
    exp_q.push_back(24'h123456);
    chk("single_valid", 32'(rd_valid), 1);
    chk("single_data", 32'(rd_data), 32'h123456);
    chk("single_level", 32'(level), 1);
    rd_ready = 1'b1;
    step();
    chk("single_drained", 32'(level), 0);
    step();
    chk("empty_pop_valid", 32'(rd_valid), 0);
    chk("empty_pop_level", 32'(level), 0);
    rd_ready = 1'b0;

    // Fill 1..8, almost_full from the 6th push
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 24'(i);
      step();
      exp_q.push_back(24'(i));
      chk("fill_level", 32'(level), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 6) ? 1 : 0);
    end
    wr_en = 1'b0;
    rd_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      step();
      chk("drain_level", 32'(level), 32'(i));
    end
    rd_ready = 1'b0;
    chk("drain_rx", 32'(rx_cnt), 9);

    // Refill, then simultaneous push/pop while full
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 24'(i);
      step();
      exp_q.push_back(24'(i));
    end
    chk("full_level", 32'(level), 8);
    rd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wr_data = 24'h000100 + 24'(k);
      step();
      exp_q.push_back(24'h000100 + 24'(k));
      chk("fullrw_level", 32'(level), 8);
    end

    // Pushes into a full FIFO are discarded
    rd_ready = 1'b0;
    for (int k = 0; k < 300; k++) begin
      wr_data = 24'hBAD000 + 24'(k);
      step();
      chk("ovf_level", 32'(level), 8);
      chk("ovf_head", 32'(rd_data), 5);
    end
    wr_en = 1'b0;
`ifdef CTE_RGB_FIFO_OVF_EN
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_cnt", 32'(drop_cnt), 255);
`endif
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    rd_ready = 1'b0;
    chk("ovf_drained", 32'(level), 0);
    chk("ovf_queue_empty", 32'(exp_q.size()), 0);

    // Async reset with five entries stored
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1; wr_data = 24'hA0 + 24'(k);
      step();
      exp_q.push_back(24'hA0 + 24'(k));
    end
    chk("pre_rst_level", 32'(level), 5);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("async_level", 32'(level), 0);
    chk("async_valid", 32'(rd_valid), 0);
    chk("async_af", 32'(almost_full), 0);
    step();
    chk("rst_push_ignored", 32'(level), 0);
    wr_en = 1'b0;
    #2;
    reset = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 24'hCAFE01;
    #1;
    chk("post_rst_nobypass", 32'(rd_valid), 0);
    step();
    wr_en = 1'b0;
    exp_q.push_back(24'hCAFE01);
    chk("post_rst_valid", 32'(rd_valid), 1);
    chk("post_rst_data", 32'(rd_data), 32'hCAFE01);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;

    // Streaming: feeder gated by almost_full, sink ready toggling
    rx_cnt = 0;
    sent = 0;
    cyc = 0;
    while ((sent < 500 || exp_q.size() != 0) && cyc < 5000) begin
      wr_en = (sent < 500) && !almost_full;
      wr_data = golden(sent);
      rd_ready = cyc[0];
      if (wr_en) begin
        if (level == 4'd8) chk("stream_drop", 1, 0);
        exp_q.push_back(golden(sent));
        sent++;
      end
      step();
      cyc++;
    end
    wr_en = 1'b0;
    rd_ready = 1'b0;
    chk("stream_timeout", (cyc < 5000) ? 1 : 0, 1);
    chk("stream_sent", 32'(sent), 500);
    chk("stream_rx", 32'(rx_cnt), 500);
    chk("stream_level", 32'(level), 0);
`ifdef CTE_RGB_FIFO_OVF_EN
    chk("stream_no_ovf", 32'(ovf), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
